// File: rtl/framebuffer_write.sv
`default_nettype none
// ============================================================================
//  Module   : framebuffer_write
//  Purpose  : Writes the received byte stream sequentially into framebuffer
//             RAM port A (ascending addresses, arrival order). One frame is
//             FRAME_BYTES bytes. frame_start arms or restarts a frame at
//             address 0.
//  Revision : 1.0 - initial release
//
//  Optional feature macro: FB_WRITE_TIMEOUT_EN
//    defined   -> an inter-byte gap counter abandons a stalled frame after
//                 TIMEOUT_CYCLES idle cycles (frame_abort pulse, back to IDLE)
//    undefined -> LOAD waits indefinitely for bytes
//
//  Ports:
//    clk_in          in   1   system clock, rising edge
//    reset           in   1   synchronous active-high reset
//    frame_start     in   1   pulse: arm a new frame at address 0
//    byte_data       in   8   received byte
//    byte_valid      in   1   byte_data valid this cycle
//    byte_ready      out  1   block accepts a byte this cycle
//    ram_data        out  8   RAM port A DataIn
//    ram_address     out  12  RAM port A Address
//    ram_clk_enable  out  1   RAM port A ClockEn
//    ram_write       out  1   RAM port A Wr
//    busy            out  1   a frame is being loaded
//    frame_done      out  1   pulse in the cycle of the last write strobe
//    frame_abort     out  1   pulse when a frame is abandoned
// ============================================================================
module framebuffer_write #(
  parameter int                         ADDR_WIDTH     = 12,
  parameter int                         DATA_WIDTH     = 8,
  parameter int                         FRAME_BYTES    = 4096,
  parameter int                         TIMEOUT_WIDTH  = 20,
  parameter logic [TIMEOUT_WIDTH-1:0]   TIMEOUT_CYCLES = 20'd1000000
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic                  frame_start,
  input  logic [DATA_WIDTH-1:0] byte_data,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic                  ram_clk_enable,
  output logic                  ram_write,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  frame_abort
);

  localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = ADDR_WIDTH'(FRAME_BYTES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_ram_data;
  logic [ADDR_WIDTH-1:0] r_ram_address;
  logic                  r_ram_write;
  logic                  r_frame_done;
  logic                  r_frame_abort;

  logic w_accept;
  logic w_last;

  // A byte presented together with frame_start belongs to the abandoned
  // frame, so it is never accepted.
  assign w_accept = (r_state == ST_LOAD) && byte_valid && !frame_start;
  assign w_last   = (r_addr == c_LAST_ADDR);

`ifdef FB_WRITE_TIMEOUT_EN
  localparam logic [TIMEOUT_WIDTH-1:0] c_TIMEOUT_LAST = TIMEOUT_CYCLES - TIMEOUT_WIDTH'(1);
  logic [TIMEOUT_WIDTH-1:0] r_gap;
  logic                     w_timeout;
  assign w_timeout = (r_gap == c_TIMEOUT_LAST);
`else
  // Timeout parameters are only consumed by the optional gap counter.
  logic [TIMEOUT_WIDTH-1:0] w_unused_timeout;
  assign w_unused_timeout = TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_addr        <= '0;
      r_ram_data    <= '0;
      r_ram_address <= '0;
      r_ram_write   <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_abort <= 1'b0;
`ifdef FB_WRITE_TIMEOUT_EN
      r_gap         <= '0;
`endif
    end else begin
      // Strobes are one-cycle pulses; data/address hold between writes.
      r_ram_write   <= w_accept;
      r_frame_done  <= 1'b0;
      r_frame_abort <= 1'b0;
      if (w_accept) begin
        r_ram_data    <= byte_data;
        r_ram_address <= r_addr;
      end

      case (r_state)
        ST_IDLE: begin
          if (frame_start) begin
            r_state <= ST_LOAD;
            r_addr  <= '0;
          end
        end
        ST_LOAD: begin
          if (frame_start) begin
            r_addr        <= '0;
            r_frame_abort <= 1'b1;
          end else if (w_accept) begin
            // The counter parks on the last address; only frame_start reloads it.
            if (w_last) begin
              r_state      <= ST_DONE;
              r_frame_done <= 1'b1;
            end else begin
              r_addr <= r_addr + ADDR_WIDTH'(1);
            end
          end
`ifdef FB_WRITE_TIMEOUT_EN
          else if (w_timeout) begin
            r_state       <= ST_IDLE;
            r_frame_abort <= 1'b1;
          end
`endif
        end
        ST_DONE: begin
          if (frame_start) begin
            r_state <= ST_LOAD;
            r_addr  <= '0;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

`ifdef FB_WRITE_TIMEOUT_EN
      if ((r_state != ST_LOAD) || frame_start || w_accept || w_timeout) begin
        r_gap <= '0;
      end else begin
        r_gap <= r_gap + TIMEOUT_WIDTH'(1);
      end
`endif
    end
  end

  // Status flags decode the state register directly, so they are glitch-free.
  assign byte_ready     = (r_state == ST_LOAD);
  assign busy           = (r_state != ST_IDLE);
  assign ram_data       = r_ram_data;
  assign ram_address    = r_ram_address;
  assign ram_write      = r_ram_write;
  assign ram_clk_enable = r_ram_write;
  assign frame_done     = r_frame_done;
  assign frame_abort    = r_frame_abort;

endmodule
`default_nettype wire

// File: tb/tb_framebuffer_write.sv
`default_nettype none
// ============================================================================
//  Module   : tb_framebuffer_write
//  Purpose  : Self-checking bench for framebuffer_write (default build).
//             Expected RAM writes are queued as bytes are driven and compared
//             against every write strobe the DUT produces.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_framebuffer_write;

  logic        clk_in = 1'b0;
  logic        reset = 1'b1;
  logic        frame_start = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic [7:0]  ram_data;
  logic [11:0] ram_address;
  logic        ram_clk_enable;
  logic        ram_write;
  logic        busy;
  logic        frame_done;
  logic        frame_abort;

  framebuffer_write dut (
    .clk_in         (clk_in),
    .reset          (reset),
    .frame_start    (frame_start),
    .byte_data      (byte_data),
    .byte_valid     (byte_valid),
    .byte_ready     (byte_ready),
    .ram_data       (ram_data),
    .ram_address    (ram_address),
    .ram_clk_enable (ram_clk_enable),
    .ram_write      (ram_write),
    .busy           (busy),
    .frame_done     (frame_done),
    .frame_abort    (frame_abort)
  );

  always #5 clk_in = ~clk_in;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_fail   = 0;
  logic [19:0] sb [$];        // {address, data} of each expected write
  logic [11:0] exp_addr = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge and are sampled at the next one.
  task automatic drive(input logic fs, input logic v, input logic [7:0] d, input logic rst);
    @(posedge clk_in);
    #1;
    frame_start = fs;
    byte_valid  = v;
    byte_data   = d;
    reset       = rst;
  endtask

  task automatic send_byte(input logic [7:0] d);
    drive(1'b0, 1'b1, d, 1'b0);
    sb.push_back({exp_addr, d});
    exp_addr = exp_addr + 12'd1;
  endtask

  task automatic start_frame();
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    exp_addr = '0;
  endtask

  // Scoreboard consumer: every write strobe must match the oldest queued byte.
  always @(negedge clk_in) begin
    logic [19:0] e;
    if (ram_clk_enable !== ram_write)
      check("ce_vs_wr", {31'd0, ram_clk_enable}, {31'd0, ram_write});
    if (ram_write === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_write_addr", {20'd0, ram_address}, 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check("wr_addr", {20'd0, ram_address}, {20'd0, e[19:8]});
        check("wr_data", {24'd0, ram_data}, {24'd0, e[7:0]});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    // ---- reset state
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    check("rst_strobes", {30'd0, ram_write, ram_clk_enable}, 32'd0);
    check("rst_flags", {28'd0, byte_ready, busy, frame_done, frame_abort}, 32'd0);
    check("rst_ram_bus", {12'd0, ram_address, ram_data}, 32'd0);
    drive(1'b0, 1'b0, 8'h00, 1'b0);

    // ---- bytes in IDLE are ignored
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 8'hC0 + 8'(i), 1'b0);
      @(negedge clk_in);
      check("idle_ready", {31'd0, byte_ready}, 32'd0);
      check("idle_wr", {31'd0, ram_write}, 32'd0);
    end

    // ---- full frame, one byte per cycle, data = addr & 8'hFF
    start_frame();
    for (int i = 0; i < 4096; i++) send_byte(exp_addr[7:0]);
    drive(1'b0, 1'b0, 8'h00, 1'b0);           // DONE cycle: final strobe
    @(negedge clk_in);
    check("done_pulse", {31'd0, frame_done}, 32'd1);
    check("done_final_addr", {20'd0, ram_address}, 32'd4095);
    check("done_ready", {31'd0, byte_ready}, 32'd0);
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    @(negedge clk_in);
    check("after_done_pulse", {31'd0, frame_done}, 32'd0);
    check("after_done_busy", {31'd0, busy}, 32'd0);
    check("frame1_drained", sb.size(), 32'd0);

    // ---- restart with frame_start after 10 bytes; 8'hAA dropped
    start_frame();
    for (int i = 0; i < 10; i++) send_byte(8'h10 + 8'(i));
    drive(1'b1, 1'b1, 8'hAA, 1'b0);
    exp_addr = '0;
    @(negedge clk_in);
    check("restart_last_strobe", {31'd0, ram_write}, 32'd1);
    send_byte(8'h55);
    @(negedge clk_in);
    check("restart_abort", {31'd0, frame_abort}, 32'd1);
    check("restart_no_wr", {31'd0, ram_write}, 32'd0);
    send_byte(8'h56);
    @(negedge clk_in);
    check("abort_one_cycle", {31'd0, frame_abort}, 32'd0);
    send_byte(8'h57);

    // ---- reset during the strobe of addr 100
    start_frame();
    for (int i = 0; i <= 100; i++) send_byte(8'(i * 3));
    drive(1'b0, 1'b0, 8'h00, 1'b1);            // strobe of addr 100 visible here
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    @(negedge clk_in);
    check("midrst_strobes", {30'd0, ram_write, ram_clk_enable}, 32'd0);
    check("midrst_flags", {28'd0, byte_ready, busy, frame_done, frame_abort}, 32'd0);
    check("midrst_ram_bus", {12'd0, ram_address, ram_data}, 32'd0);
    check("midrst_drained", sb.size(), 32'd0);

    // ---- new frame from addr 0, frame_start in the DONE cycle
    start_frame();
    for (int i = 0; i < 4096; i++) send_byte(8'(i ^ 8'h5A));
    drive(1'b1, 1'b0, 8'h00, 1'b0);           // DONE cycle with frame_start
    exp_addr = '0;
    @(negedge clk_in);
    check("done_rs_pulse", {31'd0, frame_done}, 32'd1);
    check("done_rs_busy", {31'd0, busy}, 32'd1);
    send_byte(8'h3C);
    @(negedge clk_in);
    check("rs_busy", {31'd0, busy}, 32'd1);
    check("rs_ready", {31'd0, byte_ready}, 32'd1);
    check("rs_no_abort", {31'd0, frame_abort}, 32'd0);
    send_byte(8'h3D);
    send_byte(8'h3E);

    // ---- no timeout in the default build: still LOAD after 1000 idle cycles
    for (int i = 0; i < 1000; i++) drive(1'b0, 1'b0, 8'h00, 1'b0);
    @(negedge clk_in);
    check("idle_load_busy", {31'd0, busy}, 32'd1);
    check("idle_load_ready", {31'd0, byte_ready}, 32'd1);
    check("idle_load_abort", {31'd0, frame_abort}, 32'd0);
    send_byte(8'h77);                          // lands at addr 3
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    @(negedge clk_in);
    check("final_drained", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/framebuffer_write.md
Name: framebuffer_write

Overview:
- Write-side counterpart of the framebuffer fetch path: takes the received byte stream from the UART/control path and writes it sequentially into framebuffer RAM port A (8-bit wide, 12-bit address).
- One frame is 4096 bytes, which is 2048 RGB565 pixels of 16 bits each as seen on port B.
- Sits between control_module and framebuffer port A, in the clk_in (root oscillator) domain.

Parameters:
- ADDR_WIDTH, 12, RAM port A address width.
- DATA_WIDTH, 8, RAM port A data width; equals the byte width.
- FRAME_BYTES, 4096, bytes per frame; last address is FRAME_BYTES-1.
- TIMEOUT_WIDTH, 20, width of the inter-byte gap counter (only used with the optional feature).
- TIMEOUT_CYCLES, 20'd1000000, maximum inter-byte gap before abort; about 19 ms at 53.2 MHz.

Ports:
- clk_in, input, 1, system clock; all logic is on its rising edge.
- reset, input, 1, synchronous active-high reset.
- frame_start, input, 1, single-cycle pulse that arms a new frame at address 0.
- byte_data, input, 8, received byte.
- byte_valid, input, 1, byte_data is valid this cycle.
- byte_ready, output, 1, block accepts a byte this cycle.
- ram_data, output, 8, RAM port A DataIn.
- ram_address, output, 12, RAM port A Address.
- ram_clk_enable, output, 1, RAM port A ClockEn.
- ram_write, output, 1, RAM port A Wr.
- busy, output, 1, a frame is being loaded.
- frame_done, output, 1, single-cycle pulse after the last byte is written.
- frame_abort, output, 1, single-cycle pulse when a frame is abandoned.

Behaviour:
- Reset: all outputs are 0, the state is IDLE, the address counter is 0, and any pending write is cancelled.
- State IDLE:
  - byte_ready=0 and busy=0.
  - Bytes arriving in IDLE are ignored.
  - frame_start moves to LOAD with the address counter at 0.
- State LOAD:
  - byte_ready=1 and busy=1.
  - A byte is accepted on any cycle with byte_valid & byte_ready. Back-to-back accepts are allowed, one per cycle.
- Write pipeline:
  - A byte accepted in cycle N produces ram_data=byte, ram_address=counter, ram_clk_enable=1 and ram_write=1 in cycle N+1 (one-cycle latency).
  - The strobes are high for exactly one cycle per byte.
  - The counter increments in the cycle after acceptance.
  - ram_data and ram_address hold their last values when idle; only the strobes return to 0.
- Byte order: bytes go to ascending addresses in arrival order. The host sends the RGB565 low byte first.
- Last byte: accepting the byte at address FRAME_BYTES-1 sets the next state to DONE. byte_ready drops in the following cycle.
- State DONE: lasts one cycle, which is the cycle of the final write strobe. frame_done=1 in the same cycle. The block then returns to IDLE.
- Address wrap: the counter never wraps inside a frame. After a frame completes it is reloaded to 0 only by frame_start.
- frame_start while in LOAD:
  - The frame restarts: counter to 0, the block stays in LOAD, and frame_abort pulses for one cycle.
  - A write strobe already issued for the previous cycle's byte still completes.
  - A byte presented in the same cycle as frame_start is dropped.
- frame_start while in DONE: takes effect; the block enters LOAD instead of IDLE. frame_done still pulses.
- Reset mid-frame: the frame is abandoned with no frame_abort pulse. The strobes are 0 from the next cycle.
- The block never reads the RAM. Port B fetch is unaffected and may run concurrently.

Optional Feature:
- FB_WRITE_TIMEOUT_EN defined:
  - In LOAD, a gap counter resets on each accepted byte and on frame_start, and increments otherwise.
  - When it reaches TIMEOUT_CYCLES-1, the state goes to IDLE, frame_abort pulses for one cycle, and busy drops.
  - Bytes already written stay in RAM.
- FB_WRITE_TIMEOUT_EN undefined:
  - No counter exists, and LOAD waits indefinitely.
  - frame_abort is driven only by a restart with frame_start.

Test Plan:
- Reset then frame_start, followed by 4096 bytes at one per cycle with value (addr & 8'hFF) -> each write strobe carries a matching address and data with one-cycle latency. frame_done pulses once, in the cycle of the addr 4095 strobe. busy=0 afterwards.
- Bytes arriving with byte_valid in IDLE before any frame_start -> no ram_write, byte_ready=0.
- frame_start after 10 bytes, with byte 8'hAA presented in the same cycle -> the strobe for byte 10 (addr 9) still completes, 8'hAA is dropped, frame_abort pulses, and the next byte is written to addr 0.
- reset asserted during the write strobe of addr 100 -> all outputs 0 next cycle. A subsequent frame starts at addr 0.
- With FB_WRITE_TIMEOUT_EN and TIMEOUT_CYCLES=16: 5 bytes then idle -> frame_abort after 16 idle cycles, state IDLE, a further byte is ignored. Without the macro -> still LOAD after 1000 idle cycles.
- frame_start in the DONE cycle -> frame_done pulses and busy stays 1. The next byte is written to addr 0.
